// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad matrix and writes debounced key
// codes into a downstream FIFO.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   row_i[3:0]   keypad rows, active-low, asynchronous to clk_i
//   col_o[3:0]   column drive, active-low, exactly one bit low
//   fifo_full_i  downstream FIFO full flag
//   key_valid_o  one-cycle FIFO write strobe
//   key_code_o   key code {zeros, row[1:0], col[1:0]}
//   ovf_clr_i    synchronous clear of overflow_o
//   overflow_o   sticky flag: a debounced key was dropped because the FIFO was full
//
// state       | meaning
// ------------+-------------------------------------------------------------
// SCAN        | walking the columns, one per tick, looking for any low row
// DEB_PRESS   | column frozen, latched row must stay low for DEBOUNCE_TICKS ticks
// HELD        | key accepted, waiting for the latched row to go high
// DEB_RELEASE | latched row must stay high for DEBOUNCE_TICKS ticks
module keypad_scanner #(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int DATA_WIDTH     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [3:0]            row_i,
  output logic [3:0]            col_o,
  input  logic                  fifo_full_i,
  output logic                  key_valid_o,
  output logic [DATA_WIDTH-1:0] key_code_o,
  input  logic                  ovf_clr_i,
  output logic                  overflow_o
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);

  localparam logic [1:0] ST_SCAN        = 2'd0;
  localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

  logic [3:0]            sync1_q, sync2_q;
  logic [PW-1:0]         presc_q;
  logic [1:0]            state_q, state_d;
  logic [1:0]            col_q, col_d;
  logic [1:0]            row_q, row_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] code_q, code_d;
  logic                  ovf_q, ovf_d;

  logic                  tick;
  logic                  accept;
  logic                  row_low;
  logic [1:0]            low_row;
  logic [CW-1:0]         cnt_inc;

  assign tick    = (presc_q == PW'(CLK_DIV - 1));
  assign row_low = ~sync2_q[row_q];
  assign cnt_inc = cnt_q + CW'(1);

  // Lowest-numbered low row wins when several rows are low together.
  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!sync2_q[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (&sync2_q) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = ST_DEB_PRESS;
          end
        end
        ST_DEB_PRESS: begin
          if (!row_low) begin
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
              state_d = ST_HELD;
              accept  = 1'b1;
            end
          end
        end
        ST_HELD: begin
          if (!row_low) begin
            cnt_d   = '0;
            state_d = ST_DEB_RELEASE;
          end
        end
        default: begin
          if (row_low) begin
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_TICKS)) begin
              state_d = ST_SCAN;
              col_d   = col_q + 2'd1;
            end
          end
        end
      endcase
    end
  end

  // A dropped key never disturbs the last delivered code.
  assign valid_d = accept & ~fifo_full_i;
  assign code_d  = valid_d ? DATA_WIDTH'({row_q, col_q}) : code_q;
  // Setting wins over a simultaneous clear so a drop is never lost.
  assign ovf_d   = (accept & fifo_full_i) ? 1'b1 : (ovf_clr_i ? 1'b0 : ovf_q);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      presc_q <= '0;
      state_q <= ST_SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= row_i;
      sync2_q <= sync1_q;
      presc_q <= tick ? '0 : presc_q + PW'(1);
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      ovf_q   <= ovf_d;
    end
  end

  // Decoded straight from the column register so reset drives 1110 immediately.
  assign col_o       = ~(4'b0001 << col_q);
  assign key_valid_o = valid_q;
  assign key_code_o  = code_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a behavioural
// keypad matrix and a cycle model of the scanning/debounce rules.
module tb_keypad_scanner;

  localparam int CD = 4;
  localparam int DB = 3;
  localparam int DW = 8;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [3:0]    row_i;
  logic [3:0]    col_o;
  logic          fifo_full_i;
  logic          key_valid_o;
  logic [DW-1:0] key_code_o;
  logic          ovf_clr_i;
  logic          overflow_o;

  keypad_scanner #(.CLK_DIV(CD), .DEBOUNCE_TICKS(DB), .DATA_WIDTH(DW)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .row_i       (row_i),
    .col_o       (col_o),
    .fifo_full_i (fifo_full_i),
    .key_valid_o (key_valid_o),
    .key_code_o  (key_code_o),
    .ovf_clr_i   (ovf_clr_i),
    .overflow_o  (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  // Physical keypad: key bit r*4+c shorts row r to column c.
  logic [15:0] keys;
  logic [3:0]  row_force;
  always_comb begin
    row_i = row_force;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
  end

  int total = 0;
  int bad   = 0;
  int pulses = 0;
  int ovf_cycles = 0;

  // Model: phase 0 scanning, 1 confirming press, 2 held, 3 confirming release.
  int         m_cyc, m_phase, m_run;
  logic [1:0] m_col, m_row;
  logic [3:0] h1, h2;
  logic       m_valid, m_ovf, m_acc;
  logic [7:0] m_code;

  task automatic model_reset();
    m_cyc = 0; m_phase = 0; m_run = 0; m_col = 2'd0; m_row = 2'd0;
    h1 = 4'hF; h2 = 4'hF; m_valid = 1'b0; m_ovf = 1'b0; m_code = 8'h00;
  endtask

  task automatic model_update();
    if (!rst_n_i) begin
      model_reset();
    end else begin
      m_acc = 1'b0;
      if (m_cyc % CD == CD - 1) begin
        case (m_phase)
          0: if (h2 == 4'hF) m_col = m_col + 2'd1;
             else begin
               for (int r = 3; r >= 0; r--) if (!h2[r]) m_row = 2'(r);
               m_run = 0; m_phase = 1;
             end
          1: if (h2[m_row]) m_phase = 0;
             else begin
               m_run++;
               if (m_run == DB) begin m_phase = 2; m_acc = 1'b1; end
             end
          2: if (h2[m_row]) begin m_run = 0; m_phase = 3; end
          default:
             if (!h2[m_row]) m_phase = 2;
             else begin
               m_run++;
               if (m_run == DB) begin m_phase = 0; m_col = m_col + 2'd1; end
             end
        endcase
      end
      m_cyc++;
      m_valid = m_acc && !fifo_full_i;
      if (m_valid) m_code = {4'h0, m_row, m_col};
      if (m_acc && fifo_full_i) m_ovf = 1'b1;
      else if (ovf_clr_i) m_ovf = 1'b0;
      h2 = h1;
      h1 = row_i;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_cycle();
    chk("col_o", 32'(col_o), 32'(4'hF ^ (4'b0001 << m_col)));
    chk("key_valid_o", 32'(key_valid_o), 32'(m_valid));
    chk("key_code_o", 32'(key_code_o), 32'(m_code));
    chk("overflow_o", 32'(overflow_o), 32'(m_ovf));
    if (key_valid_o === 1'b1) pulses++;
    if (overflow_o === 1'b1) ovf_cycles++;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      model_update();
      @(negedge clk_i);
      check_cycle();
    end
  endtask

  // Returns at the first negedge after col_o freshly becomes want.
  task automatic wait_col(input logic [3:0] want);
    int n;
    n = 0;
    while (col_o == want && n < 100) begin step(1); n++; end
    while (col_o != want && n < 100) begin step(1); n++; end
    if (n >= 100) begin
      total++; bad++;
      $display("FAIL wait_col timeout: got %0h want %0h", col_o, want);
    end
  endtask

  int p0, o0;

  initial begin
    rst_n_i = 1'b0; keys = 16'h0; row_force = 4'hF;
    fifo_full_i = 1'b0; ovf_clr_i = 1'b0;
    model_reset();
    step(3);
    chk("reset col_o", 32'(col_o), 32'hE);
    chk("reset key_valid_o", 32'(key_valid_o), 32'h0);
    chk("reset key_code_o", 32'(key_code_o), 32'h0);
    chk("reset overflow_o", 32'(overflow_o), 32'h0);
    rst_n_i = 1'b1;

    // Free-running scan, one column per 4 clocks.
    step(3);  chk("scan c0", 32'(col_o), 32'hE);
    step(1);  chk("scan c1", 32'(col_o), 32'hD);
    step(4);  chk("scan c2", 32'(col_o), 32'hB);
    step(4);  chk("scan c3", 32'(col_o), 32'h7);
    step(4);  chk("scan wrap", 32'(col_o), 32'hE);
    chk("scan no pulse", 32'(pulses), 32'h0);

    // Row 2 / column 1 held, then released.
    p0 = pulses;
    keys[2*4+1] = 1'b1;
    step(200);
    keys = 16'h0;
    step(100);
    chk("key21 pulses", 32'(pulses - p0), 32'd1);
    chk("key21 code", 32'(key_code_o), 32'h09);

    // One-tick glitch on row 0 in column 3.
    p0 = pulses;
    wait_col(4'h7);
    row_force = 4'b1110;
    step(4);
    row_force = 4'hF;
    step(4);
    chk("glitch col held", 32'(col_o), 32'h7);
    step(4);
    chk("glitch scan resumes", 32'(col_o), 32'hE);
    chk("glitch pulses", 32'(pulses - p0), 32'd0);

    // Rows 1 and 3 together in column 0.
    p0 = pulses;
    keys[1*4+0] = 1'b1; keys[3*4+0] = 1'b1;
    step(100);
    keys = 16'h0;
    step(60);
    chk("multi pulses", 32'(pulses - p0), 32'd1);
    chk("multi code", 32'(key_code_o), 32'h04);

    // FIFO full at acceptance of row 3 / column 3.
    p0 = pulses;
    fifo_full_i = 1'b1;
    keys[3*4+3] = 1'b1;
    step(100);
    keys = 16'h0;
    step(60);
    chk("full pulses", 32'(pulses - p0), 32'd0);
    chk("full overflow", 32'(overflow_o), 32'h1);
    chk("full code kept", 32'(key_code_o), 32'h04);
    ovf_clr_i = 1'b1;
    step(1);
    ovf_clr_i = 1'b0;
    chk("ovf cleared", 32'(overflow_o), 32'h0);

    // Clear held high across a dropped key: set wins for exactly one cycle.
    o0 = ovf_cycles;
    ovf_clr_i = 1'b1;
    keys[3*4+3] = 1'b1;
    step(100);
    keys = 16'h0;
    step(60);
    ovf_clr_i = 1'b0;
    fifo_full_i = 1'b0;
    chk("set over clr cycles", 32'(ovf_cycles - o0), 32'd1);
    chk("set over clr final", 32'(overflow_o), 32'h0);
    step(2);

    // Reset while a key is held, then the key stays down.
    p0 = pulses;
    keys[2*4+2] = 1'b1;
    step(100);
    chk("pre-reset pulses", 32'(pulses - p0), 32'd1);
    chk("pre-reset code", 32'(key_code_o), 32'h0A);
    #2 rst_n_i = 1'b0;
    model_reset();
    #1;
    chk("async col_o", 32'(col_o), 32'hE);
    chk("async key_valid_o", 32'(key_valid_o), 32'h0);
    chk("async key_code_o", 32'(key_code_o), 32'h0);
    chk("async overflow_o", 32'(overflow_o), 32'h0);
    step(2);
    rst_n_i = 1'b1;
    p0 = pulses;
    step(100);
    chk("post-reset pulses", 32'(pulses - p0), 32'd1);
    chk("post-reset code", 32'(key_code_o), 32'h0A);
    keys = 16'h0;
    step(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter CLK_DIV, default 1000, clk_i cycles per scan tick; SHALL be at least 4.
REQ-002 Parameter DEBOUNCE_TICKS, default 8, consecutive stable ticks required for press and release; SHALL be at least 1.
REQ-003 Parameter DATA_WIDTH, default 8, key code width; SHALL be at least 4.
REQ-004 clk_i  in  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst_n_i  in  1  reset, asynchronous assert, active-low.
REQ-006 row_i  in  4  keypad row lines, active-low (pulled up), asynchronous to clk_i.
REQ-007 col_o  out  4  column drive, active-low, exactly one bit low at all times.
REQ-008 fifo_full_i  in  1  downstream key FIFO full flag.
REQ-009 key_valid_o  out  1  one-cycle write strobe to the downstream FIFO wr_en.
REQ-010 key_code_o  out  DATA_WIDTH  key code to the downstream FIFO wr_data.
REQ-011 ovf_clr_i  in  1  synchronous clear of overflow_o.
REQ-012 overflow_o  out  1  sticky flag: a debounced key was dropped because the FIFO was full.

Function
REQ-013 Synchronisation: row_i SHALL pass through a 2-flop synchroniser; all row decisions SHALL use the synchronised value only.
REQ-014 Prescaler: a counter SHALL run 0..CLK_DIV-1 and wrap to 0.
- A one-cycle tick SHALL occur in the cycle the counter equals CLK_DIV-1.
- All FSM decisions SHALL occur only on tick cycles.
REQ-015 FSM states: SCAN, DEB_PRESS, HELD, DEB_RELEASE.
REQ-016 SCAN, on tick, all synchronised rows high: column index SHALL advance by one (3 wraps to 0), col_o SHALL update in the same edge.
REQ-017 SCAN, on tick, any row low: SHALL latch column index and the lowest-numbered low row, clear the debounce counter, and enter DEB_PRESS with the column held.
REQ-018 DEB_PRESS, on tick:
- Latched row low: debounce counter increments.
- Latched row high: return to SCAN with the same column and no output.
REQ-019 DEB_PRESS accept: when the counter reaches DEBOUNCE_TICKS, the FSM SHALL enter HELD and the key SHALL be accepted.
REQ-020 Acceptance with fifo_full_i low:
- key_valid_o SHALL be high for exactly the one cycle after the accepting edge.
- key_code_o SHALL be registered as {zeros, row[1:0], col[1:0]}, i.e. row*4+col.
REQ-021 Acceptance with fifo_full_i high: SHALL set overflow_o, produce no strobe, and leave key_code_o unchanged.
REQ-022 key_code_o SHALL hold its value until the next accepted key.
REQ-023 HELD, on tick: latched row high SHALL clear the counter and enter DEB_RELEASE; no further strobes SHALL occur while the key is held.
REQ-024 DEB_RELEASE, on tick:
- Latched row high: counter increments; at DEBOUNCE_TICKS, SHALL enter SCAN with the column advanced.
- Latched row low: SHALL return to HELD.
REQ-025 overflow_o: set has priority over ovf_clr_i when both occur in the same cycle.
REQ-026 Multiple keys: other rows or columns SHALL be ignored outside SCAN (no rollover, no ghost detection).

Reset
REQ-027 While rst_n_i is low, the following SHALL be forced immediately without waiting for a clock edge:
- col_o = 4'b1110, key_valid_o = 0, key_code_o = 0, overflow_o = 0.
- Prescaler = 0, debounce counter = 0, state = SCAN, synchroniser flops = 4'b1111.
REQ-028 Reset mid-press SHALL abandon the press; after reset, a strobe SHALL occur only on a fresh full debounce.

Verification (CLK_DIV=4, DEBOUNCE_TICKS=3, DATA_WIDTH=8)
REQ-029 Reset release, no keys -> col_o cycles 1110, 1101, 1011, 0111, 1110, changing every 4 clocks; key_valid_o stays 0.
REQ-030 Row 2 driven low only while col_o=1101, held for 200 clocks, then released -> exactly one key_valid_o pulse with key_code_o=8'h09; no pulse on release; scanning resumes.
REQ-031 Row 0 low for 1 tick in column 3, then high -> no pulse; FSM back in SCAN; col_o stays 0111 until the next tick.
REQ-032 Rows 1 and 3 both low in column 0 -> one pulse with key_code_o=8'h04.
REQ-033 fifo_full_i=1 at acceptance of row 3, column 3 -> no pulse, overflow_o=1, key_code_o unchanged; ovf_clr_i for 1 cycle -> overflow_o=0; set and clear in the same cycle -> overflow_o=1.
REQ-034 rst_n_i asserted in HELD -> outputs take reset values immediately; key still held after reset -> one new pulse after 3 stable ticks.
